// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from one full-adder cell and a
// registered carry. Adds two WIDTH-bit operands plus a carry-in, LSB first,
// one bit per clock, behind a start/ready/done handshake.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] sum_sh_r;
   logic             carry_r;

   logic             s_bit_s;
   logic             c_bit_s;
   logic [WIDTH-1:0] sum_next_s;

   // Carry-out of a full adder: majority of its three inputs.
   function automatic logic majority(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   // Full-adder cell on the current LSBs and the sum shift register's next value.
   always_comb begin
      s_bit_s                = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
      c_bit_s                = majority(a_sh_r[0], b_sh_r[0], carry_r);
      sum_next_s             = sum_sh_r >> 1;
      sum_next_s[WIDTH-1]    = s_bit_s;
   end

   // Control FSM, datapath shift registers and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         sum_sh_r <= '0;
         carry_r  <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_sh_r  <= a;
                  b_sh_r  <= b;
                  carry_r <= cin;
                  cnt_r   <= '0;
                  state_r <= SHIFT;
                  ready   <= 1'b0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end else begin
                  state_r <= IDLE;
                  ready   <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
            end
            SHIFT: begin
               a_sh_r   <= a_sh_r >> 1;
               b_sh_r   <= b_sh_r >> 1;
               sum_sh_r <= sum_next_s;
               carry_r  <= c_bit_s;
               cnt_r    <= cnt_r + CW'(1);
               if (cnt_r == LAST) begin
                  // Last bit: publish the full result together with the final carry.
                  sum     <= sum_next_s;
                  cout    <= c_bit_s;
                  state_r <= DONE;
                  ready   <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  state_r <= SHIFT;
                  ready   <= 1'b0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            DONE: begin
               state_r <= IDLE;
               ready   <= 1'b1;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
               ready   <= 1'b1;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder, with an
// 8-bit and a 1-bit instance checked against plain integer addition.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start8, cin8;
   logic [7:0] a8, b8;
   logic       ready8, busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start1, cin1;
   logic [0:0] a1, b1;
   logic       ready1, busy1, done1, cout1;
   logic [0:0] sum1;

   int n_tests = 0;
   int n_fail  = 0;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 8-bit addition; operands are scrambled right after acceptance.
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
      logic [8:0] exp;
      logic [7:0] prev_sum;
      logic       prev_cout;
      exp       = 9'({1'b0, ta} + {1'b0, tb} + {8'd0, tc});
      prev_sum  = sum8;
      prev_cout = cout8;
      check("op8_ready_before", 32'(ready8), 32'd1);
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
         check("op8_busy", 32'(busy8), 32'd1);
         check("op8_no_done", 32'(done8), 32'd0);
         check("op8_sum_stable", 32'({prev_cout, prev_sum}), 32'({cout8, sum8}));
         if (i == 3) start8 = 1'b1;   // start mid-operation must be ignored
         tick();
      end
      start8 = 1'b0;
      check("op8_done", 32'(done8), 32'd1);
      check("op8_busy_off", 32'(busy8), 32'd0);
      check("op8_result", 32'({cout8, sum8}), 32'(exp));
      tick();
      check("op8_done_pulse", 32'(done8), 32'd0);
      check("op8_ready_after", 32'(ready8), 32'd1);
      check("op8_result_held", 32'({cout8, sum8}), 32'(exp));
   endtask

   // One 1-bit addition: registered full adder.
   task automatic op1(input logic ta, input logic tb, input logic tc);
      int exp;
      exp = int'(ta) + int'(tb) + int'(tc);
      a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      a1 = ~ta; b1 = ~tb; cin1 = ~tc;
      check("op1_busy", 32'(busy1), 32'd1);
      tick();
      check("op1_done", 32'(done1), 32'd1);
      check("op1_result", 32'({cout1, sum1}), 32'(exp));
      tick();
      check("op1_ready", 32'(ready1), 32'd1);
      check("op1_done_off", 32'(done1), 32'd0);
   endtask

   initial begin
      // Reset held two edges with a start request pending.
      rst_n = 1'b0; start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1;
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      tick();
      tick();
      check("rst_ready", 32'(ready8), 32'd1);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_sum", 32'(sum8), 32'h00);
      check("rst_cout", 32'(cout8), 32'd0);
      check("rst_ready1", 32'(ready1), 32'd1);
      start8 = 1'b0; start1 = 1'b0;
      rst_n = 1'b1;
      tick();
      check("idle_ready", 32'(ready8), 32'd1);
      check("idle_busy", 32'(busy8), 32'd0);

      // Directed corner cases.
      op8(8'hFF, 8'h01, 1'b0);
      op8(8'hFF, 8'hFF, 1'b1);
      op8(8'h00, 8'h00, 1'b1);

      // Start held high: back-to-back operations every 10 cycles.
      a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
      for (int j = 0; j < 20; j++) begin
         tick();
         check("bb_busy", 32'(busy8), 32'((j % 10) < 8));
         check("bb_done", 32'(done8), 32'((j % 10) == 8));
         check("bb_ready", 32'(ready8), 32'((j % 10) == 9));
         if (j == 2) a8 = 8'hAA;
         if (j == 8) check("bb_result1", 32'({cout8, sum8}), 32'h08D);
         if (j == 18) check("bb_result2", 32'({cout8, sum8}), 32'h0DD);
         if (j == 19) start8 = 1'b0;
      end
      tick();
      check("bb_stop_idle", 32'(ready8), 32'd1);

      // Reset on the 4th SHIFT edge aborts the operation.
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_ready", 32'(ready8), 32'd1);
      check("abort_busy", 32'(busy8), 32'd0);
      check("abort_done", 32'(done8), 32'd0);
      check("abort_result", 32'({cout8, sum8}), 32'h000);
      for (int j = 0; j < 10; j++) begin
         tick();
         check("abort_no_done", 32'(done8), 32'd0);
      end
      op8(8'h12, 8'h34, 1'b1);

      // Randomized operations against integer addition.
      for (int n = 0; n < 25; n++) begin
         op8(8'($urandom), 8'($urandom), 1'($urandom));
      end

      // WIDTH=1: full-adder truth table sweep.
      for (int k = 0; k < 8; k++) begin
         op1(k[2], k[1], k[0]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder built around a single full-adder cell plus a registered carry. It adds two WIDTH-bit operands and a carry-in, one bit per clock, LSB first. It sits directly downstream of the combinational full adder: it consumes that cell's Sum/Cout every cycle and feeds Cout back as the next Cin. A start/ready/done handshake lets a controller issue one addition at a time.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
start  input  1  request a new addition; sampled only when ready=1.
a  input  WIDTH  operand A; captured on the accept edge.
b  input  WIDTH  operand B; captured on the accept edge.
cin  input  1  carry-in; captured on the accept edge.
ready  output  1  high in IDLE; block can accept start.
busy  output  1  high in SHIFT.
done  output  1  one-cycle pulse when the result is valid.
sum  output  WIDTH  registered result, held until the next completion or reset.
cout  output  1  registered final carry-out, held with sum.

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Outputs are decoded from state: ready=(IDLE), busy=(SHIFT), done=(DONE).
- Reset: on any rising edge with rst_n=0, the following values load:
  - state=IDLE, bit counter=0, shift registers=0, carry register=0.
  - sum=0, cout=0.
  - Resulting outputs: ready=1, busy=0, done=0.
- Reset overrides every other input, including a start on the same edge.
- IDLE to SHIFT: on an edge with start=1, the block loads a_sh<=a, b_sh<=b, carry<=cin, counter<=0.
- IDLE with start=0: the block stays in IDLE and all registers hold.
- SHIFT, each edge:
  - Compute s=a_sh[0]^b_sh[0]^carry and c=majority(a_sh[0],b_sh[0],carry).
  - Shift a_sh and b_sh right by 1.
  - Shift s into the MSB of the sum shift register.
  - Load carry<=c and increment the counter.
- SHIFT to DONE: on the edge that processes bit WIDTH-1, i.e. the WIDTH-th SHIFT edge.
  - On that same edge, sum<=final sum shift register contents and cout<=c.
- DONE to IDLE: unconditional on the next edge. A start during DONE is ignored.
- Latency: if start is accepted at edge k, sum/cout update at edge k+WIDTH. done is high for the single cycle between edges k+WIDTH and k+WIDTH+1. ready returns high after edge k+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles when start is held high.
- Start while not IDLE is ignored. It is neither queued nor counted.
- a, b and cin are ignored outside the accept edge; changing them mid-operation must not affect the result.
- Arithmetic: {cout,sum} == a + b + cin, computed at WIDTH+1 bits. There is no overflow flag; cout carries the overflow.
- sum/cout are stable (unchanged) during SHIFT. They still show the previous result until the completion edge.
- Reset mid-SHIFT aborts the operation: no done pulse, sum/cout cleared to 0, and the block is in IDLE after that edge.
- WIDTH=1: a single SHIFT cycle; the block behaves as a registered full adder.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with start=1 and a=0xFF -> ready=1, busy=0, done=0, sum=0x00, cout=0; no operation starts.
2. WIDTH=8, a=0xFF, b=0x01, cin=0, start one cycle at edge k -> busy high for 8 cycles, done pulse exactly after edge k+8, sum=0x00, cout=1.
3. WIDTH=8, a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
4. WIDTH=8, start held high continuously; a=0x5A, b=0x33, cin=0 at accept, then a changed to 0xAA mid-SHIFT -> first result sum=0x8D, cout=0. Next accept occurs exactly 10 cycles after the first, and exactly one done pulse appears per operation.
5. WIDTH=8, start a=0x80, b=0x80, cin=0, assert rst_n=0 on the 4th SHIFT edge -> no done, sum=0x00, cout=0, ready=1. Then a=0x12, b=0x34, cin=1 -> sum=0x47, cout=0.
6. WIDTH=1, sweep all 8 combinations of a, b, cin -> {cout,sum} matches the full-adder truth table, e.g. 1,1,1 -> cout=1, sum=1. done follows 1 edge after accept each time.
